// File: rtl/sync_ram_pkg.sv
// Shared constants, types and the operation encoding for the ram subsystem.
package ram_package;

  localparam int ADDR_WIDTH = 10;
  localparam int DATA_WIDTH = 4;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2
  } op_e;

endpackage

// File: rtl/sync_ram_array.sv
// Storage array with one write port and a registered read port; clr wipes
// every word and the read register in a single cycle.
module sync_ram_array
  import ram_package::*;
#(
  parameter int ADDR_WIDTH = ram_package::ADDR_WIDTH,
  parameter int DATA_WIDTH = ram_package::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [depth];

  // Whole-array clear is needed so never-written words read back as zero.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < depth; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/sync_ram.sv
// Single-port synchronous RAM: cs/we decode, synchronous active-low reset,
// oe gating of the read register and a one-cycle read-valid strobe.
module sync_ram
  import ram_package::*;
#(
  parameter int ADDR_WIDTH = ram_package::ADDR_WIDTH,
  parameter int DATA_WIDTH = ram_package::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid
);

  op_e                   op;
  logic                  clr;
  logic [DATA_WIDTH-1:0] read_reg;

  always_comb begin
    op = OP_IDLE;
    if (cs) begin
      op = we ? OP_WRITE : OP_READ;
    end
  end

  assign clr = ~reset;

  sync_ram_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk   (clk),
    .clr   (clr),
    .wr_en (op == OP_WRITE),
    .rd_en (op == OP_READ),
    .addr  (address),
    .wdata (data_in),
    .rdata (read_reg)
  );

  // rd_valid is a valid-only strobe (no ready): it is high for exactly the
  // cycle following a captured read, and the consumer must take it then.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= (op == OP_READ);
    end
  end

  assign data_out = oe ? read_reg : '0;

endmodule

// File: tb/tb_sync_ram.sv
// Directed self-checking bench for sync_ram.
module tb_sync_ram;

  localparam int AW = 10;
  localparam int DW = 4;

  logic          clk;
  logic          reset;
  logic          cs;
  logic          we;
  logic          oe;
  logic [AW-1:0] address;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          rd_valid;

  int n_cmp;
  int n_err;

  sync_ram dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .we       (we),
    .oe       (oe),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out),
    .rd_valid (rd_valid)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change on the falling edge, outputs sampled 1ns after the rising edge
  task automatic drive(input logic r, input logic c, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    reset   = r;
    cs      = c;
    we      = w;
    address = a;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(1'b1, 1'b1, 1'b1, a, d);
  endtask

  task automatic read_word(input logic [AW-1:0] a);
    drive(1'b1, 1'b1, 1'b0, a, 4'h0);
  endtask

  task automatic idle_cycle();
    drive(1'b1, 1'b0, 1'b0, '0, 4'h0);
  endtask

  task automatic test_reset();
    oe = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 10'd120, 4'hF);
    drive(1'b0, 1'b1, 1'b1, 10'd120, 4'hF);
    n_cmp++;
    if (data_out !== 4'b0000) begin
      n_err++; $display("FAIL reset_data_out: got %b want 0000", data_out);
    end
    n_cmp++;
    if (rd_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid);
    end
    read_word(10'd120);
    n_cmp++;
    if (data_out !== 4'b0000) begin
      n_err++; $display("FAIL reset_read120: got %b want 0000", data_out);
    end
    n_cmp++;
    if (rd_valid !== 1'b1) begin
      n_err++; $display("FAIL reset_read_valid: got %b want 1", rd_valid);
    end
    idle_cycle();
    n_cmp++;
    if (rd_valid !== 1'b0) begin
      n_err++; $display("FAIL valid_one_cycle: got %b want 0", rd_valid);
    end
  endtask

  task automatic test_write_read();
    write_word(10'd120, 4'b1010);
    n_cmp++;
    if (rd_valid !== 1'b0) begin
      n_err++; $display("FAIL write_no_valid: got %b want 0", rd_valid);
    end
    n_cmp++;
    if (data_out !== 4'b0000) begin
      n_err++; $display("FAIL write_keeps_read_reg: got %b want 0000", data_out);
    end
    read_word(10'd120);
    n_cmp++;
    if (data_out !== 4'b1010) begin
      n_err++; $display("FAIL write_read120: got %b want 1010", data_out);
    end
    n_cmp++;
    if (rd_valid !== 1'b1) begin
      n_err++; $display("FAIL write_read_valid: got %b want 1", rd_valid);
    end
  endtask

  task automatic test_oe_gating();
    oe = 1'b0;
    #1;
    n_cmp++;
    if (data_out !== 4'b0000) begin
      n_err++; $display("FAIL oe_low: got %b want 0000", data_out);
    end
    idle_cycle();
    oe = 1'b1;
    #1;
    n_cmp++;
    if (data_out !== 4'b1010) begin
      n_err++; $display("FAIL oe_high_again: got %b want 1010", data_out);
    end
  endtask

  task automatic test_reset_clears();
    write_word(10'd111, 4'b1111);
    read_word(10'd111);
    n_cmp++;
    if (data_out !== 4'b1111) begin
      n_err++; $display("FAIL read111: got %b want 1111", data_out);
    end
    drive(1'b0, 1'b0, 1'b0, '0, 4'h0);
    n_cmp++;
    if (data_out !== 4'b0000) begin
      n_err++; $display("FAIL reset_clears_read_reg: got %b want 0000", data_out);
    end
    read_word(10'd111);
    n_cmp++;
    if (data_out !== 4'b0000) begin
      n_err++; $display("FAIL reread111: got %b want 0000", data_out);
    end
    read_word(10'd120);
    n_cmp++;
    if (data_out !== 4'b0000) begin
      n_err++; $display("FAIL reread120: got %b want 0000", data_out);
    end
  endtask

  task automatic test_deselect();
    write_word(10'd7, 4'b0101);
    read_word(10'd7);
    n_cmp++;
    if (data_out !== 4'b0101) begin
      n_err++; $display("FAIL read7: got %b want 0101", data_out);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 10'd5, 4'b0110);
      n_cmp++;
      if (rd_valid !== 1'b0) begin
        n_err++; $display("FAIL deselect_valid[%0d]: got %b want 0", i, rd_valid);
      end
      n_cmp++;
      if (data_out !== 4'b0101) begin
        n_err++; $display("FAIL deselect_hold[%0d]: got %b want 0101", i, data_out);
      end
    end
    read_word(10'd5);
    n_cmp++;
    if (data_out !== 4'b0000) begin
      n_err++; $display("FAIL deselect_read5: got %b want 0000", data_out);
    end
  endtask

  task automatic test_boundary();
    write_word(10'd0, 4'b0011);
    write_word(10'd1023, 4'b1100);
    read_word(10'd0);
    n_cmp++;
    if (data_out !== 4'b0011) begin
      n_err++; $display("FAIL read_addr0: got %b want 0011", data_out);
    end
    read_word(10'd1023);
    n_cmp++;
    if (data_out !== 4'b1100) begin
      n_err++; $display("FAIL read_addr1023: got %b want 1100", data_out);
    end
    read_word(10'd512);
    n_cmp++;
    if (data_out !== 4'b0000) begin
      n_err++; $display("FAIL read_addr512: got %b want 0000", data_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [4];
    logic [DW-1:0] vals  [4];
    addrs = '{10'd200, 10'd201, 10'd340, 10'd999};
    vals  = '{4'b0001, 4'b1110, 4'b0111, 4'b1001};
    for (int i = 0; i < 4; i++) write_word(addrs[i], vals[i]);
    for (int i = 0; i < 4; i++) begin
      read_word(addrs[i]);
      n_cmp++;
      if (data_out !== vals[i] || rd_valid !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_read[%0d]: got %b/%b want %b/1", i, data_out, rd_valid, vals[i]);
      end
    end
    // write then immediate read of the same word
    write_word(10'd201, 4'b0100);
    read_word(10'd201);
    n_cmp++;
    if (data_out !== 4'b0100) begin
      n_err++; $display("FAIL wr_then_rd: got %b want 0100", data_out);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset   = 1'b0;
    cs      = 1'b0;
    we      = 1'b0;
    oe      = 1'b0;
    address = '0;
    data_in = '0;
    test_reset();
    test_write_read();
    test_oe_gating();
    test_reset_clears();
    test_deselect();
    test_boundary();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_ram.md
Name: sync_ram

Overview:
- Single-port synchronous static RAM, 1024 words x 4 bits, chip-select/write-enable/output-enable control.
- Leaf storage block in the ram subsystem.
- Connected through the subsystem's interface bundle; interface signal names match the port names below.
- Driven by the environment's driver and checked by its monitor/scoreboard.

Parameters:
- ADDR_WIDTH, 10, address bits; depth = 2**ADDR_WIDTH = 1024 words.
- DATA_WIDTH, 4, bits per word.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset asserted), sampled on rising clk.
- cs  input  1  chip select, active-high; no access when 0.
- we  input  1  write enable, active-high; 1 = write, 0 = read (qualified by cs).
- oe  input  1  output enable, active-high; gates data_out.
- address  input  ADDR_WIDTH  word address, 0..1023.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  read data when oe=1; 0 when oe=0.
- rd_valid  output  1  high for one cycle after a read access was captured.

Behaviour:
- Reset (reset==0 at rising clk):
  - All 1024 words cleared to 0 in the same cycle.
  - Read register cleared to 0; rd_valid=0; data_out therefore 0.
  - Reset overrides any cs/we activity in that cycle; no write occurs.
- Write (reset==1, cs==1, we==1): mem[address] <= data_in at the rising edge.
  - Read register is unchanged; rd_valid <= 0.
- Read (reset==1, cs==1, we==0): read register <= mem[address] at the rising edge; rd_valid <= 1 for that cycle.
  - Latency: 1 clock from address presentation to data in the read register.
- Idle (cs==0): memory and read register hold; rd_valid <= 0.
  - we, address and data_in are ignored.
- Output: data_out = oe ? read_reg : 0. This is combinational on oe; no tri-state.
  - Toggling oe never alters memory or read_reg.
- Same address, write in cycle N then read in cycle N+1: returns the newly written data.
- Back-to-back reads to different addresses: one new word per cycle.
- Read of a never-written location after reset returns 0.
- X/Z on control inputs is not required to be handled.
- Memory is retained indefinitely while reset==1.

Decomposition:
- Package ram_package holds:
  - constants ADDR_WIDTH=10, DATA_WIDTH=4, DEPTH=1024;
  - typedefs addr_t = logic [ADDR_WIDTH-1:0] and data_t = logic [DATA_WIDTH-1:0];
  - enum op_e {OP_IDLE, OP_WRITE, OP_READ}, used by the environment's transaction class.
- One sub-module is natural: sync_ram_array.
  - Holds the storage array plus the write port and registered read port.
  - The top adds reset handling, cs/we decode, the oe gating and rd_valid.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then read address 120 with oe=1 -> data_out=4'b0000, rd_valid=1 the cycle after the read.
- Write/read: cs=1,we=1,address=120,data_in=4'b1010 for one cycle; then cs=1,we=0 with the same address; then oe=1 -> data_out=4'b1010.
- oe gating:
  - After reading 4'b1010, drive oe=0 -> data_out=4'b0000.
  - Drive oe=1 again -> 4'b1010 without a new access.
- Self-check then reset:
  - Write 4'b1111 at address 111, read it with oe=1 -> 4'b1111.
  - Assert reset=0 one cycle, then re-read 111 -> 4'b0000.
- Deselect:
  - With cs=0,we=1,address=5,data_in=4'b0110, clock 3 cycles.
  - Then read address 5 -> 4'b0000; rd_valid stays 0 during the cs=0 cycles.
- Boundary:
  - Write 4'b0011 at address 0 and 4'b1100 at address 1023.
  - Read back -> 4'b0011 and 4'b1100; address 512 still 4'b0000.
